// File: rtl/moving_sum_pkg.sv
// Shared definitions for the moving_sum_win sliding-window filter.
package moving_sum_pkg;

  typedef enum logic {
    StFill   = 1'b0,
    StSteady = 1'b1
  } ms_state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/moving_sum_ring.sv
// DEPTH x DW ring buffer; rdata is the oldest entry, the one the next write replaces.
module moving_sum_ring
  import moving_sum_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = clogb2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          clr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DEPTH-1:0][DW-1:0] mem_q;
  logic [AW-1:0]            wptr_q;

  // Pointer wraps on its own since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
    end else if (clr) begin
      mem_q  <= '0;
      wptr_q <= '0;
    end else if (wr_en) begin
      mem_q[wptr_q] <= wdata;
      wptr_q        <= wptr_q + AW'(1);
    end
  end

  assign rdata = mem_q[wptr_q];

endmodule

// File: rtl/moving_sum_win.sv
// Sliding-window moving sum over the last DEPTH accepted samples, 1-cycle latency.
// Optional rounded average output enabled by defining MOVING_SUM_AVG_EN.
module moving_sum_win
  import moving_sum_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = clogb2(DEPTH),
  localparam int unsigned OW   = DW + AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          din_vld,
  input  logic [DW-1:0] din,
  output logic          dout_vld,
  output logic [OW-1:0] dout,
  output logic          full
`ifdef MOVING_SUM_AVG_EN
 ,output logic [DW-1:0] dout_avg
`endif
);

  localparam int unsigned FW = AW + 1;
  localparam int unsigned PW = OW + 1 - DW;

  logic          accept;
  logic [DW-1:0] oldest;
  logic [OW-1:0] sum_q, sum_d, sum_nxt;
  logic          vld_q, vld_d;
  logic [FW-1:0] fill_q, fill_d;
  ms_state_e     state_q, state_d;

  assign accept = din_vld & ~clr;

  moving_sum_ring #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (accept),
    .clr   (clr),
    .wdata (din),
    .rdata (oldest)
  );

  // One guard bit so the intermediate add/subtract cannot wrap; the result always fits OW.
  assign sum_nxt = OW'({1'b0, sum_q} + {{PW{1'b0}}, din} - {{PW{1'b0}}, oldest});

  always_comb begin
    sum_d   = sum_q;
    vld_d   = 1'b0;
    fill_d  = fill_q;
    state_d = state_q;
    if (clr) begin
      sum_d   = '0;
      fill_d  = '0;
      state_d = StFill;
    end else if (din_vld) begin
      sum_d = sum_nxt;
      vld_d = 1'b1;
      if (fill_q != FW'(DEPTH)) fill_d = fill_q + FW'(1);
      case (state_q)
        StFill:   if (fill_q == FW'(DEPTH - 1)) state_d = StSteady;
        StSteady: state_d = StSteady;
        default:  state_d = StFill;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      vld_q   <= 1'b0;
      fill_q  <= '0;
      state_q <= StFill;
    end else begin
      sum_q   <= sum_d;
      vld_q   <= vld_d;
      fill_q  <= fill_d;
      state_q <= state_d;
    end
  end

  assign dout     = sum_q;
  assign dout_vld = vld_q;
  assign full     = (state_q == StSteady);

`ifdef MOVING_SUM_AVG_EN
  logic [DW-1:0] avg_q, avg_d;

  // Always divides by DEPTH, also during fill; +DEPTH/2 rounds half up.
  always_comb begin
    avg_d = avg_q;
    if (clr) begin
      avg_d = '0;
    end else if (din_vld) begin
      avg_d = DW'((sum_nxt + OW'(DEPTH / 2)) >> AW);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) avg_q <= '0;
    else        avg_q <= avg_d;
  end

  assign dout_avg = avg_q;
`endif

endmodule

// File: tb/tb_moving_sum_win.sv
// Directed bench for moving_sum_win: a DEPTH=4 and a DEPTH=8 instance on one clock.
module tb_moving_sum_win;

  logic clk;
  logic rst_n;

  logic        clr_a, vld_a, clr_b, vld_b;
  logic [7:0]  din_a, din_b;
  logic        dvld_a, full_a, dvld_b, full_b;
  logic [9:0]  dout_a;
  logic [10:0] dout_b;
`ifdef MOVING_SUM_AVG_EN
  logic [7:0]  avg_a, avg_b;
`endif

  int n_checks = 0;
  int n_errors = 0;

  moving_sum_win #(
    .DW    (8),
    .DEPTH (4)
  ) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_a),
    .din_vld  (vld_a),
    .din      (din_a),
    .dout_vld (dvld_a),
    .dout     (dout_a),
    .full     (full_a)
`ifdef MOVING_SUM_AVG_EN
   ,.dout_avg (avg_a)
`endif
  );

  moving_sum_win #(
    .DW    (8),
    .DEPTH (8)
  ) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_b),
    .din_vld  (vld_b),
    .din      (din_b),
    .dout_vld (dvld_b),
    .dout     (dout_b),
    .full     (full_b)
`ifdef MOVING_SUM_AVG_EN
   ,.dout_avg (avg_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Present a sample, clock once, then look at outputs 1 ns after the edge.
  task automatic push_a(input logic [7:0] d);
    din_a = d;
    vld_a = 1'b1;
    @(posedge clk);
    #1;
    vld_a = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] d);
    din_b = d;
    vld_b = 1'b1;
    @(posedge clk);
    #1;
    vld_b = 1'b0;
  endtask

  task automatic idle_a();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    clr_a = 1'b1;
    @(posedge clk);
    #1;
    clr_a = 1'b0;
  endtask

  logic [9:0] exp_ramp [6] = '{10'd1, 10'd3, 10'd6, 10'd10, 10'd14, 10'd18};

  initial begin
    rst_n = 1'b0;
    clr_a = 1'b0; vld_a = 1'b0; din_a = '0;
    clr_b = 1'b0; vld_b = 1'b0; din_b = '0;
    #12 rst_n = 1'b1;
    idle_a();

    check("rst_dout", 32'(dout_a), 0);
    check("rst_vld", 32'(dvld_a), 0);
    check("rst_full", 32'(full_a), 0);
    check("rst_dout_b", 32'(dout_b), 0);

    // Ramp 1..6 through DEPTH=4: fill then slide.
    for (int i = 0; i < 6; i++) begin
      push_a(8'(i + 1));
      check($sformatf("ramp_dout%0d", i), 32'(dout_a), 32'(exp_ramp[i]));
      check($sformatf("ramp_vld%0d", i), 32'(dvld_a), 1);
      check($sformatf("ramp_full%0d", i), 32'(full_a), (i >= 3) ? 1 : 0);
    end
    idle_a();
    check("idle_vld", 32'(dvld_a), 0);
    check("idle_hold", 32'(dout_a), 18);

    // clr wins over a simultaneous sample.
    din_a = 8'd9;
    vld_a = 1'b1;
    clr_a = 1'b1;
    @(posedge clk);
    #1;
    vld_a = 1'b0;
    clr_a = 1'b0;
    check("clr_dout", 32'(dout_a), 0);
    check("clr_full", 32'(full_a), 0);
    check("clr_vld", 32'(dvld_a), 0);
    push_a(8'd7);
    check("after_clr", 32'(dout_a), 7);
    check("after_clr_full", 32'(full_a), 0);

    // Gap in the sample stream.
    clear_a();
    push_a(8'd1);
    push_a(8'd2);
    check("gap_pre", 32'(dout_a), 3);
    for (int i = 0; i < 3; i++) begin
      idle_a();
      check($sformatf("gap_vld%0d", i), 32'(dvld_a), 0);
      check($sformatf("gap_dout%0d", i), 32'(dout_a), 3);
    end
    push_a(8'd3);
    check("gap_post", 32'(dout_a), 6);
    check("gap_full", 32'(full_a), 0);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    check("arst_dout", 32'(dout_a), 0);
    check("arst_full", 32'(full_a), 0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_a(8'd2);
      check($sformatf("refill%0d", i), 32'(dout_a), 32'(2 * (i + 1)));
      check($sformatf("refill_full%0d", i), 32'(full_a), (i == 3) ? 1 : 0);
    end

    // DEPTH=8 saturating window.
    for (int i = 0; i < 8; i++) begin
      push_b(8'd255);
      if (i == 0) check("b_first", 32'(dout_b), 255);
      if (i == 6) check("b_full7", 32'(full_b), 0);
    end
    check("b_max", 32'(dout_b), 2040);
    check("b_full", 32'(full_b), 1);
    push_b(8'd0);
    check("b_slide", 32'(dout_b), 1785);
    check("b_full_hold", 32'(full_b), 1);

`ifdef MOVING_SUM_AVG_EN
    clear_a();
    check("avg_clr", 32'(avg_a), 0);
    push_a(8'd1); check("avg0", 32'(avg_a), 0);
    push_a(8'd2); check("avg1", 32'(avg_a), 1);
    push_a(8'd3); check("avg2", 32'(avg_a), 2);
    push_a(8'd4); check("avg3", 32'(avg_a), 3);
    for (int i = 0; i < 4; i++) push_a(8'd255);
    check("avg_max", 32'(avg_a), 255);
    check("avg_b", 32'(avg_b), 223);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
